sort_ctrl: RTL and testbench

Sequencing controller for the in-place selection-sort engine. It owns the single-port sort RAM during a run. It issues every read and write address and the write data, tracks the outer index i, the scan index j and the running-minimum index min, and performs the swap. It sits between the top-level start/done handshake and the RAM. Ascending order, unsigned compare.

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sort_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and default sizes for the in-place selection-sort engine.
package sort_pkg;

  localparam int unsigned DEF_SIZE_ADDR = 8;
  localparam int unsigned DEF_SIZE_DATA = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_I = 4'd1,
    CAP_I  = 4'd2,
    RD_J   = 4'd3,
    CMP_J  = 4'd4,
    SWAP_A = 4'd5,
    SWAP_B = 4'd6,
    NEXT_I = 4'd7,
    DONE   = 4'd8
  } sort_state_e;

endpackage

// File: rtl/sort_ctrl.sv
// Selection-sort sequencer: owns the single-port sort RAM for a run, scans for the
// minimum of the unsorted tail and swaps it into place, ascending unsigned order.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned SIZE_ADDR = DEF_SIZE_ADDR,
  parameter int unsigned SIZE_DATA = DEF_SIZE_DATA
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR:0]   i_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_rd_en,
  output logic                 o_wr_en,
  output logic [SIZE_ADDR-1:0] o_addr,
  output logic [SIZE_DATA-1:0] o_wr_data,
  input  logic [SIZE_DATA-1:0] i_rd_data,
  output logic [SIZE_ADDR-1:0] o_swap_cnt
);

  // Indices carry one extra bit so i+1 and j reach 2**SIZE_ADDR without wrapping.
  localparam int unsigned IDX_W = SIZE_ADDR + 1;
  localparam logic [IDX_W-1:0] LEN_MAX = {1'b1, {SIZE_ADDR{1'b0}}};

  sort_state_e            state_q, state_d;
  logic [IDX_W-1:0]       len_q, len_d;
  logic [IDX_W-1:0]       i_q, i_d;
  logic [IDX_W-1:0]       j_q, j_d;
  logic [IDX_W-1:0]       min_q, min_d;
  logic [SIZE_DATA-1:0]   val_i_q, val_i_d;
  logic [SIZE_DATA-1:0]   val_min_q, val_min_d;
  logic [SIZE_ADDR-1:0]   swap_cnt_d;

  logic                   rd_en_d, wr_en_d;
  logic [SIZE_ADDR-1:0]   addr_d;
  logic [SIZE_DATA-1:0]   wr_data_d;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    i_d        = i_q;
    j_d        = j_q;
    min_d      = min_q;
    val_i_d    = val_i_q;
    val_min_d  = val_min_q;
    swap_cnt_d = o_swap_cnt;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          len_d      = (i_len > LEN_MAX) ? LEN_MAX : i_len;
          i_d        = '0;
          swap_cnt_d = '0;
          state_d    = (len_d < IDX_W'(2)) ? DONE : LOAD_I;
        end
      end
      LOAD_I: state_d = CAP_I;
      CAP_I: begin
        val_i_d   = i_rd_data;
        val_min_d = i_rd_data;
        min_d     = i_q;
        j_d       = i_q + IDX_W'(1);
        state_d   = RD_J;
      end
      RD_J: state_d = CMP_J;
      CMP_J: begin
        // Strict compare keeps the first minimum, so equal keys never move.
        if (i_rd_data < val_min_q) begin
          min_d     = j_q;
          val_min_d = i_rd_data;
        end
        if (j_q == len_q - IDX_W'(1)) begin
          state_d = (min_d != i_q) ? SWAP_A : NEXT_I;
        end else begin
          j_d     = j_q + IDX_W'(1);
          state_d = RD_J;
        end
      end
      SWAP_A: state_d = SWAP_B;
      SWAP_B: begin
        swap_cnt_d = o_swap_cnt + SIZE_ADDR'(1);
        state_d    = NEXT_I;
      end
      NEXT_I: begin
        if (i_q == len_q - IDX_W'(2)) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + IDX_W'(1);
          state_d = LOAD_I;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM strobe decode of the upcoming state; address and data hold when no strobe.
  always_comb begin
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    addr_d    = o_addr;
    wr_data_d = o_wr_data;

    case (state_d)
      LOAD_I: begin
        rd_en_d = 1'b1;
        addr_d  = SIZE_ADDR'(i_d);
      end
      RD_J: begin
        rd_en_d = 1'b1;
        addr_d  = SIZE_ADDR'(j_d);
      end
      SWAP_A: begin
        wr_en_d   = 1'b1;
        addr_d    = SIZE_ADDR'(min_d);
        wr_data_d = val_i_d;
      end
      SWAP_B: begin
        wr_en_d   = 1'b1;
        addr_d    = SIZE_ADDR'(i_d);
        wr_data_d = val_min_d;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      min_q      <= '0;
      val_i_q    <= '0;
      val_min_q  <= '0;
      o_swap_cnt <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rd_en    <= 1'b0;
      o_wr_en    <= 1'b0;
      o_addr     <= '0;
      o_wr_data  <= '0;
    end else begin
      len_q      <= len_d;
      i_q        <= i_d;
      j_q        <= j_d;
      min_q      <= min_d;
      val_i_q    <= val_i_d;
      val_min_q  <= val_min_d;
      o_swap_cnt <= swap_cnt_d;
      o_busy     <= (state_d != IDLE);
      o_done     <= (state_d == DONE);
      o_rd_en    <= rd_en_d;
      o_wr_en    <= wr_en_d;
      o_addr     <= addr_d;
      o_wr_data  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl: directed runs push expected results, a monitor
// checks RAM contents, swap count, run length and access counts at each o_done.
module tb_sort_ctrl;
  import sort_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef struct {
    int n;
    int nchk;
    int swaps;
    int cycles;
    int writes;
    int reads;
    logic [255:0][7:0] mem;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW-1:0] swap_cnt;

  logic [DW-1:0] mem [256];

  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;
  int conflicts = 0;
  int cyc = 0, nrd = 0, nwr = 0;
  exp_t sb_q[$];

  sort_ctrl #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_wr_en(wr_en),
    .o_addr(addr), .o_wr_data(wr_data), .i_rd_data(rd_data),
    .o_swap_cnt(swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[addr];
    if (wr_en) mem[addr] <= wr_data;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set4(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  function automatic exp_t mk4(input int n, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d,
                               input int sw, input int cy, input int rd);
    exp_t e;
    e.n = n; e.nchk = 4; e.swaps = sw; e.cycles = cy;
    e.writes = 2 * sw; e.reads = rd;
    e.mem = '0;
    e.mem[0] = a; e.mem[1] = b; e.mem[2] = c; e.mem[3] = d;
    return e;
  endfunction

  // Monitor: counts activity per run and scores each o_done against the queue.
  initial begin : monitor
    int bad;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0; nrd = 0; nwr = 0;
      end else begin
        if (rd_en && wr_en) begin
          conflicts++;
          $display("FAIL rd_wr_overlap at addr %0d: got both strobes expected one", addr);
        end
        if (busy) cyc++;
        if (rd_en) nrd++;
        if (wr_en) nwr++;
        if (done) begin
          done_seen++;
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("done_busy", busy, 1);
            check("swap_cnt", swap_cnt, e.swaps);
            check("run_cycles", cyc, e.cycles);
            check("ram_writes", nwr, e.writes);
            check("ram_reads", nrd, e.reads);
            bad = 0;
            for (int k = 0; k < e.nchk; k++)
              if (mem[k] !== e.mem[k]) bad++;
            check("ram_mismatches", bad, 0);
          end
          cyc = 0; nrd = 0; nwr = 0;
        end
      end
    end
  end

  task automatic run(input int n, input exp_t e, input bit pulse);
    int n0, t;
    @(negedge clk);
    len = (AW+1)'(n);
    start = 1'b1;
    sb_q.push_back(e);
    n0 = done_seen;
    @(negedge clk);
    start = 1'b0;
    #1;
    t = 0;
    while (done_seen == n0 && t < 70000) begin
      if (pulse && (t % 3 == 1)) begin
        start = 1'b1;
        len = (AW+1)'(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      #1;
      t++;
    end
    start = 1'b0;
    if (done_seen == n0) check("done_timeout", t, -1);
  endtask

  initial begin : stim
    exp_t e;
    int t;
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, rd_en, wr_en, addr, wr_data, swap_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_quiet", {busy, done, rd_en, wr_en, addr, wr_data, swap_cnt}, 0);
    end

    set4(8'd5, 8'd3, 8'd8, 8'd1);
    run(4, mk4(4, 8'd1, 8'd3, 8'd5, 8'd8, 2, 26, 9), 1'b0);

    set4(8'd1, 8'd2, 8'd3, 8'd4);
    run(4, mk4(4, 8'd1, 8'd2, 8'd3, 8'd4, 0, 22, 9), 1'b0);

    set4(8'd2, 8'd2, 8'd1, 8'd2);
    run(4, mk4(4, 8'd1, 8'd2, 8'd2, 8'd2, 1, 24, 9), 1'b1);

    set4(8'd7, 8'd6, 8'd5, 8'd4);
    run(0, mk4(0, 8'd7, 8'd6, 8'd5, 8'd4, 0, 1, 0), 1'b0);
    run(1, mk4(1, 8'd7, 8'd6, 8'd5, 8'd4, 0, 1, 0), 1'b0);

    set4(8'd9, 8'd4, 8'd7, 8'd0);
    run(2, mk4(2, 8'd4, 8'd9, 8'd7, 8'd0, 1, 8, 2), 1'b0);

    // Abort a run in its first swap write, then restart on the residual contents.
    set4(8'd5, 8'd3, 8'd8, 8'd1);
    @(negedge clk);
    len = (AW+1)'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!wr_en && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("swap_a_reached", wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_midrun_outputs", {busy, done, rd_en, wr_en, addr, wr_data, swap_cnt}, 0);
    repeat (2) @(negedge clk);
    check("rst_no_write", mem[3], 1);
    rst_n = 1'b1;
    run(4, mk4(4, 8'd1, 8'd3, 8'd5, 8'd8, 2, 26, 9), 1'b0);

    for (int k = 0; k < 256; k++) mem[k] = 8'(255 - k);
    e.n = 256; e.nchk = 256; e.swaps = 128; e.cycles = 66302;
    e.writes = 256; e.reads = 32895;
    for (int k = 0; k < 256; k++) e.mem[k] = 8'(k);
    run(256, e, 1'b0);

    repeat (3) @(negedge clk);
    check("rd_wr_overlap_total", conflicts, 0);
    check("queue_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
